// File: rtl/adder_accum.sv
// Accumulates batches of 5-bit adder results into a saturating total.
// Holds each batch total until the downstream handshake.
module adder_accum #(
  parameter int N_SAMPLES = 4,
  parameter int ACC_W     = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_cout,
  input  logic [3:0]       in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam logic [0:0] S_ACC  = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;
  localparam int CNT_W = 8;

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W:0] opnd;
  logic [ACC_W:0] sum_ext;
  logic           take;
  logic           last;

  assign opnd    = (ACC_W+1)'({in_cout, in_sum});
  assign sum_ext = {1'b0, acc} + opnd;
  assign take    = in_valid & in_ready;
  assign last    = (cnt == CNT_W'(N_SAMPLES - 1));

  assign in_ready  = (state == S_ACC) & ~iRst;
  assign out_valid = (state == S_FULL);
  assign out_acc   = acc;
  assign out_ovf   = ovf;

  // Batch state: accumulate beats, then hold total until handshake.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= S_ACC;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (take) begin
            if (sum_ext[ACC_W]) begin
              acc <= '1;
              ovf <= 1'b1;
            end else begin
              acc <= sum_ext[ACC_W-1:0];
            end
            cnt <= cnt + 1'b1;
            if (last) state <= S_FULL;
          end
        end
        S_FULL: begin
          if (out_ready) begin
            state <= S_ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_accum.sv
// Scoreboard bench for adder_accum.
// Three instances cover default, narrow and single-beat builds.
module tb_adder_accum;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic [2:0] vin  = '0;
  logic [2:0] cout = '0;
  logic [3:0] sm [3];
  logic [2:0] ordy = '1;
  logic [2:0] irdy;
  logic [2:0] ovld;
  logic [2:0] ovf;
  logic [7:0] acc0;
  logic [5:0] acc1;
  logic [7:0] acc2;

  typedef struct {
    int idx;
    int acc;
    bit ovf;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_acc [3];
  int   m_cnt [3];
  bit   m_ovf [3];
  int   ns    [3];
  int   aw    [3];

  always #5 iClk = ~iClk;

  adder_accum #(.N_SAMPLES(4), .ACC_W(8)) u0 (
    .iClk(iClk), .iRst(iRst),
    .in_valid(vin[0]), .in_ready(irdy[0]),
    .in_cout(cout[0]), .in_sum(sm[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]),
    .out_acc(acc0), .out_ovf(ovf[0])
  );

  adder_accum #(.N_SAMPLES(4), .ACC_W(6)) u1 (
    .iClk(iClk), .iRst(iRst),
    .in_valid(vin[1]), .in_ready(irdy[1]),
    .in_cout(cout[1]), .in_sum(sm[1]),
    .out_valid(ovld[1]), .out_ready(ordy[1]),
    .out_acc(acc1), .out_ovf(ovf[1])
  );

  adder_accum #(.N_SAMPLES(1), .ACC_W(8)) u2 (
    .iClk(iClk), .iRst(iRst),
    .in_valid(vin[2]), .in_ready(irdy[2]),
    .in_cout(cout[2]), .in_sum(sm[2]),
    .out_valid(ovld[2]), .out_ready(ordy[2]),
    .out_acc(acc2), .out_ovf(ovf[2])
  );

  function automatic int get_acc(int k);
    case (k)
      0:       return int'(acc0);
      1:       return int'(acc1);
      default: return int'(acc2);
    endcase
  endfunction

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0;
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  task automatic model_beat(int k, int v);
    int s;
    int mx;
    exp_t e;
    mx = (1 << aw[k]) - 1;
    s  = m_acc[k] + v;
    if (s > mx) begin
      m_acc[k] = mx;
      m_ovf[k] = 1'b1;
    end else begin
      m_acc[k] = s;
    end
    m_cnt[k]++;
    if (m_cnt[k] == ns[k]) begin
      e.idx = k;
      e.acc = m_acc[k];
      e.ovf = m_ovf[k];
      q.push_back(e);
      m_acc[k] = 0;
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  // Present one beat, wait for acceptance, then drop in_valid.
  task automatic send(int k, int v);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    vin[k] = 1'b1;
    {cout[k], sm[k]} = 5'(v);
    while (!ok && n < 50) begin
      @(negedge iClk);
      if (irdy[k]) ok = 1'b1;
      else n++;
    end
    if (!ok) chk("send_timeout", int'(irdy[k]), 1);
    @(posedge iClk);
    #1;
    vin[k] = 1'b0;
    if (ok) model_beat(k, v);
  endtask

  // Pop and compare at every result handshake.
  always @(negedge iClk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (!iRst && ovld[k] && ordy[k]) begin
        if (q.size() == 0) begin
          chk("unexpected_out", q.size(), 1);
        end else begin
          e = q.pop_front();
          chk("res_idx", k, e.idx);
          chk("res_acc", get_acc(k), e.acc);
          chk("res_ovf", int'(ovf[k]), int'(e.ovf));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ns = '{4, 4, 1};
    aw = '{8, 6, 8};
    for (int k = 0; k < 3; k++) sm[k] = '0;
    model_clear();

    // reset behaviour
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", int'(irdy[k]), 0);
      chk("rst_out_valid", int'(ovld[k]), 0);
      chk("rst_out_acc", get_acc(k), 0);
      chk("rst_out_ovf", int'(ovf[k]), 0);
    end
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    @(negedge iClk);
    for (int k = 0; k < 3; k++) chk("post_rst_ready", int'(irdy[k]), 1);
    @(posedge iClk);
    #1;

    // basic back-to-back batch
    send(0, 3);
    send(0, 5);
    send(0, 18);
    send(0, 15);
    chk("b2b_valid", int'(ovld[0]), 1);
    chk("b2b_acc", get_acc(0), 41);
    chk("b2b_ovf", int'(ovf[0]), 0);
    @(posedge iClk);
    #1;
    chk("b2b_valid_drop", int'(ovld[0]), 0);
    chk("b2b_ready_back", int'(irdy[0]), 1);

    // hold under back-pressure, inputs ignored
    ordy[0] = 1'b0;
    send(0, 1);
    send(0, 2);
    send(0, 3);
    send(0, 4);
    vin[0] = 1'b1;
    {cout[0], sm[0]} = 5'd31;
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      chk("hold_valid", int'(ovld[0]), 1);
      chk("hold_acc", get_acc(0), 10);
      chk("hold_ready", int'(irdy[0]), 0);
    end
    @(posedge iClk);
    #1;
    vin[0]  = 1'b0;
    ordy[0] = 1'b1;
    @(posedge iClk);
    #1;
    chk("hold_release", int'(ovld[0]), 0);
    chk("fresh_acc", get_acc(0), 0);
    for (int i = 0; i < 4; i++) send(0, 2);
    chk("fresh_batch", get_acc(0), 8);

    // gapped beats
    @(posedge iClk);
    #1;
    for (int i = 0; i < 4; i++) begin
      send(0, 7);
      if (i < 3) begin
        chk("gap_not_done", int'(ovld[0]), 0);
        @(posedge iClk);
        #1;
      end
    end
    chk("gap_valid", int'(ovld[0]), 1);
    chk("gap_acc", get_acc(0), 28);
    @(posedge iClk);
    #1;

    // saturation on 6-bit build, then clean batch
    for (int i = 0; i < 4; i++) send(1, 31);
    chk("sat_acc", get_acc(1), 63);
    chk("sat_ovf", int'(ovf[1]), 1);
    @(posedge iClk);
    #1;
    for (int i = 0; i < 4; i++) send(1, 1);
    chk("unsat_acc", get_acc(1), 4);
    chk("unsat_ovf", int'(ovf[1]), 0);
    @(posedge iClk);
    #1;

    // reset aborts a partial batch
    send(0, 10);
    send(0, 10);
    iRst = 1'b1;
    @(negedge iClk);
    chk("midrst_ready", int'(irdy[0]), 0);
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    model_clear();
    chk("midrst_acc", get_acc(0), 0);
    for (int i = 0; i < 4; i++) send(0, 1);
    chk("midrst_result", get_acc(0), 4);
    @(posedge iClk);
    #1;

    // single-beat batches, ready toggling
    for (int v = 1; v <= 3; v++) begin
      send(2, v);
      vin[2] = 1'b1;
      chk("n1_valid", int'(ovld[2]), 1);
      chk("n1_acc", get_acc(2), v);
      chk("n1_ready_low", int'(irdy[2]), 0);
    end
    vin[2] = 1'b0;
    repeat (3) @(posedge iClk);
    #1;

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_accum.md
ADDER_ACCUM -- requirements
Module: adder_accum

Interface
REQ-001 Parameter: N_SAMPLES, default 4, beats per batch, legal range 1..255.
REQ-002 Parameter: ACC_W, default 8, accumulator/result width, legal range 5..32.
REQ-003 Port: iClk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: iRst  input  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  input  1  upstream adder result present this cycle.
REQ-006 Port: in_ready  output  1  block accepts an input beat this cycle.
REQ-007 Port: in_cout  input  1  upstream adder carry-out, operand bit 4.
REQ-008 Port: in_sum  input  4  upstream adder sum, operand bits 3:0.
REQ-009 Port: out_valid  output  1  batch result available.
REQ-010 Port: out_ready  input  1  downstream accepts result this cycle.
REQ-011 Port: out_acc  output  ACC_W  saturated batch total.
REQ-012 Port: out_ovf  output  1  batch total saturated.

Function
REQ-013 Operand SHALL be the 5-bit unsigned value {in_cout, in_sum}, range 0..31, zero-extended to ACC_W.
REQ-014 Beat accepted iff in_valid and in_ready both high at a rising edge; no other cycle alters accumulator or beat count.
REQ-015 Block SHALL have two states: ACC (collecting) and FULL (holding result).
REQ-016 ACC: in_ready=1, out_valid=0; each accepted beat adds operand to accumulator and increments beat count.
REQ-017 Accepting beat number N_SAMPLES (count N_SAMPLES-1 before the edge) SHALL transition to FULL; out_valid=1 on the very next cycle with out_acc holding the total including that beat.
REQ-018 FULL: in_ready=0, out_valid=1; out_acc and out_ovf SHALL remain stable until handshake; in_valid ignored.
REQ-019 FULL with out_ready=1 at an edge: return to ACC, accumulator, beat count and overflow flag cleared; out_valid=0 next cycle.
REQ-020 Minimum batch period SHALL be N_SAMPLES+1 cycles (N_SAMPLES beats plus one hold cycle); no same-cycle input acceptance in FULL.
REQ-021 Saturation: if accumulator+operand exceeds 2^ACC_W-1, accumulator SHALL become all-ones and overflow flag SHALL set; flag is sticky until the batch handshake.
REQ-022 Once saturated, further beats in the batch SHALL be counted but accumulator stays all-ones.
REQ-023 out_acc SHALL reflect the running accumulator in ACC; value is meaningful only when out_valid=1.
REQ-024 out_ready in ACC SHALL have no effect.

Reset
REQ-025 iRst high at an edge SHALL force: state ACC, accumulator 0, beat count 0, overflow flag 0, out_valid 0, out_acc 0, out_ovf 0.
REQ-026 While iRst is high, in_ready SHALL be 0; first cycle after iRst falls in_ready=1.
REQ-027 Reset mid-batch or during FULL SHALL discard all partial/held results; no output produced for the aborted batch.

Verification (N_SAMPLES=4, ACC_W=8 unless stated)
REQ-028 Beats (0,3),(0,5),(1,2),(0,15) back-to-back, out_ready=1 -> out_valid=1 one cycle after 4th beat, out_acc=41, out_ovf=0, out_valid low next cycle.
REQ-029 Full batch then out_ready=0 for 5 cycles with in_valid=1 -> out_valid, out_acc stable, in_ready=0, no beats counted; after out_ready=1 next batch starts from 0.
REQ-030 Four beats of value 7 with one-cycle in_valid gaps between each -> out_acc=28, exactly four beats counted.
REQ-031 ACC_W=6, four beats of (1,15)=31 -> out_acc=63, out_ovf=1; following batch of four 1s -> out_acc=4, out_ovf=0.
REQ-032 Two beats of 10 then iRst for one cycle, then four beats of 1 -> single result out_acc=4; no result for aborted batch.
REQ-033 N_SAMPLES=1, in_valid and out_ready held high, values 1,2,3 -> out_acc 1,2,3 on alternating cycles, in_ready toggling 1/0.
